bp_be_ptw_miss_arbiter: RTL and testbench

//  Requester-side end of the PTW miss/fill interface. Collects ITLB and DTLB misses and holds one

---
 rtl/bp_be_ptw_miss_arbiter_if.sv | 50 +++++
 rtl/bp_be_ptw_miss_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_bp_be_ptw_miss_arbiter.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bp_be_ptw_miss_arbiter_if.sv
// TLB-facing and walker-facing signals of the PTW miss arbiter.
// slave = the arbiter itself, master = the TLB/walker environment driving it.
interface bp_be_ptw_miss_arbiter_if #(
    parameter int vaddr_width_p = 39,
    parameter int ptag_width_p  = 28
);
    localparam int entry_width_lp    = ptag_width_p + 7;
    localparam int miss_pkt_width_lp = vaddr_width_p + 3;
    localparam int fill_pkt_width_lp = vaddr_width_p + entry_width_lp + 6;

    logic                         itlb_miss_v_i;
    logic [vaddr_width_p-1:0]     itlb_miss_vaddr_i;
    logic                         itlb_ready_o;
    logic                         dtlb_miss_v_i;
    logic                         dtlb_store_i;
    logic [vaddr_width_p-1:0]     dtlb_miss_vaddr_i;
    logic                         dtlb_ready_o;
    logic                         flush_i;
    logic                         ptw_busy_i;
    logic [miss_pkt_width_lp-1:0] ptw_miss_pkt_o;
    logic [fill_pkt_width_lp-1:0] ptw_fill_pkt_i;
    logic                         itlb_fill_v_o;
    logic [entry_width_lp-1:0]    itlb_fill_entry_o;
    logic [vaddr_width_p-1:0]     itlb_fill_vaddr_o;
    logic                         instr_page_fault_o;
    logic                         dtlb_fill_v_o;
    logic [entry_width_lp-1:0]    dtlb_fill_entry_o;
    logic [vaddr_width_p-1:0]     dtlb_fill_vaddr_o;
    logic                         load_page_fault_o;
    logic                         store_page_fault_o;
    logic                         err_o;

    modport slave (
        input  itlb_miss_v_i, itlb_miss_vaddr_i, dtlb_miss_v_i, dtlb_store_i, dtlb_miss_vaddr_i,
        input  flush_i, ptw_busy_i, ptw_fill_pkt_i,
        output itlb_ready_o, dtlb_ready_o, ptw_miss_pkt_o,
        output itlb_fill_v_o, itlb_fill_entry_o, itlb_fill_vaddr_o, instr_page_fault_o,
        output dtlb_fill_v_o, dtlb_fill_entry_o, dtlb_fill_vaddr_o,
        output load_page_fault_o, store_page_fault_o, err_o
    );

    modport master (
        output itlb_miss_v_i, itlb_miss_vaddr_i, dtlb_miss_v_i, dtlb_store_i, dtlb_miss_vaddr_i,
        output flush_i, ptw_busy_i, ptw_fill_pkt_i,
        input  itlb_ready_o, dtlb_ready_o, ptw_miss_pkt_o,
        input  itlb_fill_v_o, itlb_fill_entry_o, itlb_fill_vaddr_o, instr_page_fault_o,
        input  dtlb_fill_v_o, dtlb_fill_entry_o, dtlb_fill_vaddr_o,
        input  load_page_fault_o, store_page_fault_o, err_o
    );
endinterface

// File: rtl/bp_be_ptw_miss_arbiter.sv
// Requester side of the PTW miss/fill link: one pending slot per TLB, one walk at a time.
// Optional BP_BE_PTW_ARB_ROUND_ROBIN_EN replaces DTLB-first priority with round-robin.
module bp_be_ptw_miss_arbiter #(
    parameter int vaddr_width_p = 39,
    parameter int ptag_width_p  = 28
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    bp_be_ptw_miss_arbiter_if.slave io
);
    localparam int entry_width_lp = ptag_width_p + 7;
    localparam int flag_base_lp   = entry_width_lp + vaddr_width_p;

    typedef enum logic [1:0] {
        e_idle  = 2'd0,
        e_issue = 2'd1,
        e_wait  = 2'd2,
        e_resp  = 2'd3
    } state_e;

    state_e r_state, w_state_n;

    logic                      r_islot_v, r_dslot_v, r_dslot_store;
    logic [vaddr_width_p-1:0]  r_islot_vaddr, r_dslot_vaddr;
    logic                      r_sel_d, r_squash, r_err;
    logic                      r_fill_ipf, r_fill_dpf;
    logic [vaddr_width_p-1:0]  r_fill_vaddr;
    logic [entry_width_lp-1:0] r_fill_entry;

    logic                      w_fill_v, w_fill_ipf, w_fill_dpf;
    logic [vaddr_width_p-1:0]  w_fill_vaddr, w_slot_vaddr;
    logic                      w_i_avail, w_pick_d, w_i_flush_sel, w_fire, w_resp;
    logic                      w_i_ready, w_i_accept, w_i_clear, w_i_inflight;
    logic                      w_d_accept, w_d_clear, w_err_set;
    logic                      w_i_deliver, w_d_deliver;

    assign w_fill_v     = io.ptw_fill_pkt_i[flag_base_lp + 5];
    assign w_fill_ipf   = io.ptw_fill_pkt_i[flag_base_lp + 2];
    assign w_fill_dpf   = io.ptw_fill_pkt_i[flag_base_lp + 1] | io.ptw_fill_pkt_i[flag_base_lp];
    assign w_fill_vaddr = io.ptw_fill_pkt_i[entry_width_lp +: vaddr_width_p];
    assign w_slot_vaddr = r_sel_d ? r_dslot_vaddr : r_islot_vaddr;

    // A flush hides the ITLB slot from selection in the same cycle it is dropped.
    assign w_i_avail     = r_islot_v & ~io.flush_i;
    assign w_i_inflight  = ~r_sel_d & ((r_state == e_wait) | (r_state == e_resp));
    assign w_i_flush_sel = (r_state == e_issue) & ~r_sel_d & io.flush_i;
    assign w_fire        = (r_state == e_issue) & ~io.ptw_busy_i & ~w_i_flush_sel;
    assign w_resp        = (r_state == e_resp);

    assign w_i_ready  = ~r_islot_v & ~io.flush_i;
    assign w_i_accept = io.itlb_miss_v_i & w_i_ready;
    assign w_i_clear  = (io.flush_i & r_islot_v & ~w_i_inflight) | (w_resp & ~r_sel_d);
    assign w_d_accept = io.dtlb_miss_v_i & ~r_dslot_v;
    assign w_d_clear  = w_resp & r_sel_d;

    assign w_err_set = w_fill_v & ((r_state == e_idle) | (r_state == e_issue) |
                                   ((r_state == e_wait) & (w_fill_vaddr != w_slot_vaddr)));

`ifdef BP_BE_PTW_ARB_ROUND_ROBIN_EN
    logic r_last_d;

    assign w_pick_d = r_dslot_v & (~w_i_avail | ~r_last_d);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_last_d <= 1'b0;
        end else if (w_fire) begin
            r_last_d <= r_sel_d;
        end else begin
            r_last_d <= r_last_d;
        end
    end
`else
    assign w_pick_d = r_dslot_v;
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= e_idle;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            e_idle: begin
                if (w_i_avail | r_dslot_v) w_state_n = e_issue;
                else                       w_state_n = e_idle;
            end
            e_issue: begin
                if (w_i_flush_sel) w_state_n = e_idle;
                else if (w_fire)   w_state_n = e_wait;
                else               w_state_n = e_issue;
            end
            e_wait: begin
                if (w_fill_v) w_state_n = e_resp;
                else          w_state_n = e_wait;
            end
            e_resp:  w_state_n = e_idle;
            default: w_state_n = e_idle;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_islot_v     <= 1'b0;
            r_islot_vaddr <= '0;
        end else if (w_i_accept) begin
            r_islot_v     <= 1'b1;
            r_islot_vaddr <= io.itlb_miss_vaddr_i;
        end else if (w_i_clear) begin
            r_islot_v     <= 1'b0;
            r_islot_vaddr <= r_islot_vaddr;
        end else begin
            r_islot_v     <= r_islot_v;
            r_islot_vaddr <= r_islot_vaddr;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_dslot_v     <= 1'b0;
            r_dslot_store <= 1'b0;
            r_dslot_vaddr <= '0;
        end else if (w_d_accept) begin
            r_dslot_v     <= 1'b1;
            r_dslot_store <= io.dtlb_store_i;
            r_dslot_vaddr <= io.dtlb_miss_vaddr_i;
        end else if (w_d_clear) begin
            r_dslot_v     <= 1'b0;
            r_dslot_store <= r_dslot_store;
            r_dslot_vaddr <= r_dslot_vaddr;
        end else begin
            r_dslot_v     <= r_dslot_v;
            r_dslot_store <= r_dslot_store;
            r_dslot_vaddr <= r_dslot_vaddr;
        end
    end

    // Selection is frozen on leaving e_idle; squash marks an ITLB walk orphaned by a flush.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_sel_d  <= 1'b0;
            r_squash <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_sel_d  <= (r_state == e_idle) ? w_pick_d : r_sel_d;
            if (w_resp)                                                r_squash <= 1'b0;
            else if ((r_state == e_wait) & ~r_sel_d & io.flush_i)      r_squash <= 1'b1;
            else                                                       r_squash <= r_squash;
            r_err    <= r_err | w_err_set;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_fill_ipf   <= 1'b0;
            r_fill_dpf   <= 1'b0;
            r_fill_vaddr <= '0;
            r_fill_entry <= '0;
        end else if ((r_state == e_wait) & w_fill_v) begin
            r_fill_ipf   <= w_fill_ipf;
            r_fill_dpf   <= w_fill_dpf;
            r_fill_vaddr <= w_fill_vaddr;
            r_fill_entry <= io.ptw_fill_pkt_i[entry_width_lp-1:0];
        end else begin
            r_fill_ipf   <= r_fill_ipf;
            r_fill_dpf   <= r_fill_dpf;
            r_fill_vaddr <= r_fill_vaddr;
            r_fill_entry <= r_fill_entry;
        end
    end

    assign w_i_deliver = w_resp & ~r_sel_d & ~r_squash;
    assign w_d_deliver = w_resp & r_sel_d;

    assign io.itlb_ready_o   = w_i_ready;
    assign io.dtlb_ready_o   = ~r_dslot_v;
    assign io.ptw_miss_pkt_o = w_fire ? {~r_sel_d, r_sel_d & ~r_dslot_store, r_sel_d & r_dslot_store,
                                         w_slot_vaddr} : '0;

    assign io.itlb_fill_v_o      = w_i_deliver & ~r_fill_ipf;
    assign io.instr_page_fault_o = w_i_deliver & r_fill_ipf;
    assign io.itlb_fill_entry_o  = w_i_deliver ? r_fill_entry : '0;
    assign io.itlb_fill_vaddr_o  = w_i_deliver ? r_fill_vaddr : '0;

    // DTLB faults are reported by the kind of access the slot recorded.
    assign io.dtlb_fill_v_o      = w_d_deliver & ~r_fill_dpf;
    assign io.load_page_fault_o  = w_d_deliver & r_fill_dpf & ~r_dslot_store;
    assign io.store_page_fault_o = w_d_deliver & r_fill_dpf & r_dslot_store;
    assign io.dtlb_fill_entry_o  = w_d_deliver ? r_fill_entry : '0;
    assign io.dtlb_fill_vaddr_o  = w_d_deliver ? r_fill_vaddr : '0;

    assign io.err_o = r_err;
endmodule

// File: tb/tb_bp_be_ptw_miss_arbiter.sv
// Self-checking bench for bp_be_ptw_miss_arbiter: directed scenarios plus randomized misses
// checked against a transaction-level model of slot occupancy, selection order and responses.
module tb_bp_be_ptw_miss_arbiter;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    bit          m_pend_i, m_pend_d, m_store_d, m_last_d, m_err;
    logic [38:0] m_vi, m_vd;

    bp_be_ptw_miss_arbiter_if #(.vaddr_width_p(39), .ptag_width_p(28)) bus ();

    bp_be_ptw_miss_arbiter #(.vaddr_width_p(39), .ptag_width_p(28)) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .io        (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit model_pick_d();
`ifdef BP_BE_PTW_ARB_ROUND_ROBIN_EN
        if (m_pend_d && m_pend_i) return !m_last_d;
`endif
        return m_pend_d;
    endfunction

    function automatic logic [38:0] rand_va();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[38:0];
    endfunction

    function automatic logic [34:0] rand_entry();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[34:0];
    endfunction

    task automatic accept(input bit di, input bit dd, input logic [38:0] vi, input logic [38:0] vd,
                          input bit st);
        bus.itlb_miss_v_i = di;  bus.itlb_miss_vaddr_i = vi;
        bus.dtlb_miss_v_i = dd;  bus.dtlb_miss_vaddr_i = vd;  bus.dtlb_store_i = st;
        tick();
        bus.itlb_miss_v_i = 1'b0;
        bus.dtlb_miss_v_i = 1'b0;
        if (di) begin m_pend_i = 1'b1; m_vi = vi; end
        if (dd) begin m_pend_d = 1'b1; m_vd = vd; m_store_d = st; end
    endtask

    // One complete walk of whichever slot the model says goes next.
    task automatic do_walk(input bit fault, input bit flush_mid, input bit bad_va,
                           input logic [34:0] en, input int exp_lat);
        bit          pd, sq;
        int          n;
        logic [38:0] va, fv, gv, ev;
        logic [34:0] ge, ee;
        logic [41:0] exp_pkt;
        logic [4:0]  got5, exp5;
        pd = model_pick_d();
        va = pd ? m_vd : m_vi;
        exp_pkt = {~pd, pd & ~m_store_d, pd & m_store_d, va};
        n = 0;
        #1;
        while (bus.ptw_miss_pkt_o === '0 && n < 30) begin tick(); #1; n++; end
        total++;
        if (bus.ptw_miss_pkt_o !== exp_pkt)
            begin bad++; $display("FAIL miss_pkt got=%h want=%h", bus.ptw_miss_pkt_o, exp_pkt); end
        if (exp_lat >= 0) begin
            total++;
            if (n != exp_lat) begin bad++; $display("FAIL issue_latency got=%0d want=%0d", n, exp_lat); end
        end
        tick(); #1;
        total++;
        if (bus.ptw_miss_pkt_o !== '0)
            begin bad++; $display("FAIL pkt_one_cycle got=%h want=0", bus.ptw_miss_pkt_o); end
        if (flush_mid) begin
            bus.flush_i = 1'b1; #1;
            total++;
            if (bus.itlb_ready_o !== 1'b0)
                begin bad++; $display("FAIL ready_during_flush got=%b want=0", bus.itlb_ready_o); end
            tick();
            bus.flush_i = 1'b0;
        end
        sq = flush_mid & ~pd;
        fv = bad_va ? (va ^ 39'd1) : va;
        bus.ptw_fill_pkt_i = {1'b1, ~pd, pd, ~pd & fault, pd & fault & ~m_store_d, pd & fault & m_store_d, fv, en};
        tick();
        bus.ptw_fill_pkt_i = '0;
        #1;
        if (bad_va) m_err = 1'b1;
        exp5 = {~pd & ~sq & ~fault, ~pd & ~sq & fault, pd & ~fault, pd & fault & ~m_store_d, pd & fault & m_store_d};
        got5 = {bus.itlb_fill_v_o, bus.instr_page_fault_o, bus.dtlb_fill_v_o,
                bus.load_page_fault_o, bus.store_page_fault_o};
        total++;
        if (got5 !== exp5) begin bad++; $display("FAIL resp_flags got=%b want=%b", got5, exp5); end
        if (pd) begin ge = bus.dtlb_fill_entry_o; gv = bus.dtlb_fill_vaddr_o; end
        else    begin ge = bus.itlb_fill_entry_o; gv = bus.itlb_fill_vaddr_o; end
        ee = sq ? 35'd0 : en;
        ev = sq ? 39'd0 : fv;
        total++;
        if ({ge, gv} !== {ee, ev}) begin bad++; $display("FAIL resp_data got=%h/%h want=%h/%h", ge, gv, ee, ev); end
        total++;
        if (bus.err_o !== m_err) begin bad++; $display("FAIL err_after_resp got=%b want=%b", bus.err_o, m_err); end
        if (pd) m_pend_d = 1'b0; else m_pend_i = 1'b0;
        m_last_d = pd;
        tick(); #1;
        got5 = {bus.itlb_fill_v_o, bus.instr_page_fault_o, bus.dtlb_fill_v_o,
                bus.load_page_fault_o, bus.store_page_fault_o};
        total++;
        if ((pd ? bus.dtlb_ready_o : bus.itlb_ready_o) !== 1'b1 || got5 !== 5'd0)
            begin bad++; $display("FAIL slot_freed got=%b/%b want=1/00000", pd ? bus.dtlb_ready_o : bus.itlb_ready_o, got5); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.itlb_ready_o, bus.dtlb_ready_o} !== 2'b11)
            begin bad++; $display("FAIL reset_ready got=%b want=11", {bus.itlb_ready_o, bus.dtlb_ready_o}); end
        total++;
        if (bus.ptw_miss_pkt_o !== '0) begin bad++; $display("FAIL reset_pkt got=%h want=0", bus.ptw_miss_pkt_o); end
        total++;
        if ({bus.itlb_fill_v_o, bus.instr_page_fault_o, bus.dtlb_fill_v_o, bus.load_page_fault_o,
             bus.store_page_fault_o, bus.err_o} !== 6'd0)
            begin bad++; $display("FAIL reset_outputs got=nonzero want=000000"); end
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_itlb();
        accept(1'b1, 1'b0, 39'h40_0000_1000, 39'd0, 1'b0);
        do_walk(1'b0, 1'b0, 1'b0, {28'h123, 7'h5b}, 1);
    endtask

    task automatic test_both_same_cycle();
        accept(1'b1, 1'b1, rand_va(), rand_va(), 1'b0);
        do_walk(1'b0, 1'b0, 1'b0, rand_entry(), -1);
        do_walk(1'b0, 1'b0, 1'b0, rand_entry(), -1);
    endtask

    task automatic test_dtlb_store_fault();
        accept(1'b0, 1'b1, 39'd0, rand_va(), 1'b1);
        do_walk(1'b1, 1'b0, 1'b0, rand_entry(), 1);
    endtask

    task automatic test_busy();
        bus.ptw_busy_i = 1'b1;
        accept(1'b0, 1'b1, 39'd0, rand_va(), 1'b0);
        for (int k = 0; k < 6; k++) begin
            #1;
            total++;
            if (bus.ptw_miss_pkt_o !== '0) begin bad++; $display("FAIL busy_hold cyc=%0d got=%h want=0", k, bus.ptw_miss_pkt_o); end
            tick();
        end
        bus.ptw_busy_i = 1'b0;
        do_walk(1'b0, 1'b0, 1'b0, rand_entry(), 0);
    endtask

    task automatic test_flush();
        accept(1'b1, 1'b0, rand_va(), 39'd0, 1'b0);
        do_walk(1'b0, 1'b1, 1'b0, rand_entry(), 1);
        for (int v = 0; v < 2; v++) begin
            bus.ptw_busy_i = (v == 1);
            accept(1'b1, 1'b0, rand_va(), 39'd0, 1'b0);
            if (v == 1) tick();
            bus.flush_i = 1'b1;
            tick();
            bus.flush_i = 1'b0;
            bus.ptw_busy_i = 1'b0;
            m_pend_i = 1'b0;
            for (int k = 0; k < 4; k++) begin
                #1;
                total++;
                if (bus.ptw_miss_pkt_o !== '0) begin bad++; $display("FAIL flush_drop v=%0d got=%h want=0", v, bus.ptw_miss_pkt_o); end
                tick();
            end
            total++;
            if (bus.itlb_ready_o !== 1'b1) begin bad++; $display("FAIL flush_slot_empty got=%b want=1", bus.itlb_ready_o); end
        end
        bus.flush_i = 1'b1; bus.itlb_miss_v_i = 1'b1; bus.itlb_miss_vaddr_i = rand_va();
        #1;
        total++;
        if (bus.itlb_ready_o !== 1'b0) begin bad++; $display("FAIL flush_vs_miss_ready got=%b want=0", bus.itlb_ready_o); end
        tick();
        bus.flush_i = 1'b0; bus.itlb_miss_v_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            total++;
            if (bus.ptw_miss_pkt_o !== '0) begin bad++; $display("FAIL flush_vs_miss_pkt got=%h want=0", bus.ptw_miss_pkt_o); end
            tick();
        end
    endtask

    task automatic test_random();
        int mode;
        for (int it = 0; it < 16; it++) begin
            mode = $urandom_range(1, 3);
            accept(mode[0], mode[1], rand_va(), rand_va(), 1'($urandom_range(0, 1)));
            while (m_pend_i || m_pend_d)
                do_walk($urandom_range(0, 3) == 0, 1'b0, 1'b0, rand_entry(), -1);
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    task automatic test_vaddr_mismatch();
        accept(1'b0, 1'b1, 39'd0, rand_va(), 1'b0);
        do_walk(1'b0, 1'b0, 1'b1, rand_entry(), 1);
    endtask

    task automatic test_stray_fill();
        bus.ptw_fill_pkt_i = {1'b1, 79'd0};
        tick();
        bus.ptw_fill_pkt_i = '0;
        m_err = 1'b1;
        repeat (3) tick();
        #1;
        total++;
        if (bus.err_o !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", bus.err_o); end
    endtask

    task automatic test_reset_mid_walk();
        int          n;
        logic [38:0] vd;
        vd = rand_va();
        accept(1'b0, 1'b1, 39'd0, vd, 1'b0);
        n = 0;
        while (bus.ptw_miss_pkt_o === '0 && n < 30) begin tick(); #1; n++; end
        tick();
        bus.ptw_fill_pkt_i = {1'b1, 1'b0, 1'b1, 3'b000, vd, rand_entry()};
        tick();
        bus.ptw_fill_pkt_i = '0;
        #1;
        total++;
        if (bus.dtlb_fill_v_o !== 1'b1) begin bad++; $display("FAIL pre_reset_fill got=%b want=1", bus.dtlb_fill_v_o); end
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.dtlb_fill_v_o, bus.err_o, bus.dtlb_ready_o, bus.itlb_ready_o} !== 4'b0011)
            begin bad++; $display("FAIL async_reset got=%b want=0011", {bus.dtlb_fill_v_o, bus.err_o, bus.dtlb_ready_o, bus.itlb_ready_o}); end
        tick();
        rst_n = 1'b1;
        m_pend_i = 1'b0; m_pend_d = 1'b0; m_last_d = 1'b0; m_err = 1'b0;
        tick();
        bus.ptw_fill_pkt_i = {1'b1, 1'b0, 1'b1, 3'b000, vd, 35'd0};
        tick();
        bus.ptw_fill_pkt_i = '0;
        #1;
        total++;
        if (bus.err_o !== 1'b1) begin bad++; $display("FAIL stray_after_reset got=%b want=1", bus.err_o); end
    endtask

    initial begin
        total = 0; bad = 0;
        m_pend_i = 1'b0; m_pend_d = 1'b0; m_store_d = 1'b0; m_last_d = 1'b0; m_err = 1'b0;
        m_vi = '0; m_vd = '0;
        bus.itlb_miss_v_i = 1'b0; bus.itlb_miss_vaddr_i = '0;
        bus.dtlb_miss_v_i = 1'b0; bus.dtlb_store_i = 1'b0; bus.dtlb_miss_vaddr_i = '0;
        bus.flush_i = 1'b0; bus.ptw_busy_i = 1'b0; bus.ptw_fill_pkt_i = '0;
        test_reset();
        test_single_itlb();
        test_both_same_cycle();
        test_dtlb_store_fault();
        test_busy();
        test_flush();
        test_random();
        test_vaddr_mismatch();
        test_stray_fill();
        test_reset_mid_walk();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
